// File: rtl/param_mux_sequencer.sv
// -----------------------------------------------------------------------------
// param_mux_sequencer
//   Registered NUM_CH-channel, WIDTH-bit multiplexer with a built-in channel
//   sequencer. In MANUAL mode the channel requested on Select is forwarded.
//   In SCAN mode the channels are stepped through in order, dwelling DWELL
//   cycles on each one.
//
// Ports
//   clk      : single clock, rising edge
//   rst      : synchronous active-low reset
//   In       : flattened channels, channel k at In[k*WIDTH +: WIDTH]
//   Select   : channel request, used in MANUAL mode only
//   Mode     : 0 = MANUAL, 1 = SCAN (takes effect one clock after sampling)
//   Hold     : 1 = freeze every register; Switched reads 0 while held
//   Out      : registered data of the selected channel
//   Ch_Out   : index of the channel currently driven on Out
//   Switched : one-cycle pulse in the cycle a new Ch_Out value first appears
// -----------------------------------------------------------------------------
module param_mux_sequencer #(
   parameter int WIDTH  = 4,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = 2,
   parameter int DWELL  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH*WIDTH-1:0] In,
   input  logic [SEL_W-1:0]        Select,
   input  logic                    Mode,
   input  logic                    Hold,
   output logic [WIDTH-1:0]        Out,
   output logic [SEL_W-1:0]        Ch_Out,
   output logic                    Switched
);

   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

   // One extra bit so NUM_CH = 2**SEL_W is representable for the range check.
   localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W + 1)'(NUM_CH);
   localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

   typedef enum logic {
      MANUAL = 1'b0,
      SCAN   = 1'b1
   } state_t;

   state_t             state_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [CNT_W-1:0]   cnt_next;
   logic [SEL_W-1:0]   ch_next;
   logic [WIDTH-1:0]   data_next;

   // Unflattened view of the input bus.
   logic [WIDTH-1:0]   ch_data [NUM_CH];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
         assign ch_data[gi] = In[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Channel and dwell-counter selection for the coming edge.
   always_comb begin
      ch_next  = Ch_Out;
      cnt_next = '0;
      if (state_reg == SCAN) begin
         if (cnt_reg == LAST_CNT) begin
            // Wrap at NUM_CH, which may be below 2**SEL_W.
            ch_next = (Ch_Out == LAST_CH) ? '0 : Ch_Out + SEL_W'(1);
         end else begin
            cnt_next = cnt_reg + CNT_W'(1);
         end
      end else if ({1'b0, Select} < NUM_CH_W) begin
         // Out-of-range requests fall through and keep the current channel.
         ch_next = Select;
      end
   end

   // Data mux keyed on ch_next so Out reflects the new channel immediately.
   always_comb begin
      data_next = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (ch_next == SEL_W'(k)) begin
            data_next = ch_data[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= MANUAL;
         cnt_reg   <= '0;
         Ch_Out    <= '0;
         Out       <= '0;
         Switched  <= 1'b0;
      end else if (Hold) begin
         Switched  <= 1'b0;
      end else begin
         state_reg <= Mode ? SCAN : MANUAL;
         cnt_reg   <= cnt_next;
         Ch_Out    <= ch_next;
         Out       <= data_next;
         Switched  <= (ch_next != Ch_Out);
      end
   end

endmodule

// File: tb/tb_param_mux_sequencer.sv
// -----------------------------------------------------------------------------
// tb_param_mux_sequencer
//   Bench for param_mux_sequencer. Instance a uses the default parameters
//   (4 channels, DWELL=4); instance b uses 3 channels with DWELL=2 so that
//   out-of-range requests and the NUM_CH wrap are exercised. Directed steps
//   follow the intended behaviour, then a randomized phase runs against an
//   integer reference model.
// -----------------------------------------------------------------------------
module tb_param_mux_sequencer;

   logic        clk;
   logic        rst;
   logic [15:0] in_a;
   logic [11:0] in_b;
   logic [1:0]  sel;
   logic        mode;
   logic        hold;

   logic [3:0]  out_a, out_b;
   logic [1:0]  ch_a, ch_b;
   logic        sw_a, sw_b;

   int tests;
   int fails;

   // Reference model state, index 0 = instance a, 1 = instance b.
   int m_ch   [2];
   int m_cnt  [2];
   int m_scan [2];
   int m_out  [2];
   int m_sw   [2];

   param_mux_sequencer #(.WIDTH(4), .NUM_CH(4), .SEL_W(2), .DWELL(4)) dut_a (
      .clk(clk), .rst(rst), .In(in_a), .Select(sel), .Mode(mode), .Hold(hold),
      .Out(out_a), .Ch_Out(ch_a), .Switched(sw_a)
   );

   param_mux_sequencer #(.WIDTH(4), .NUM_CH(3), .SEL_W(2), .DWELL(2)) dut_b (
      .clk(clk), .rst(rst), .In(in_b), .Select(sel), .Mode(mode), .Hold(hold),
      .Out(out_b), .Ch_Out(ch_b), .Switched(sw_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural rules of one clock edge for one instance.
   task automatic model_edge(input int i, input int nch, input int dwell,
                             input logic [15:0] data);
      int prev;
      if (!rst) begin
         m_ch[i] = 0; m_cnt[i] = 0; m_scan[i] = 0; m_out[i] = 0; m_sw[i] = 0;
      end else if (hold) begin
         m_sw[i] = 0;
      end else begin
         prev = m_ch[i];
         if (m_scan[i] == 0) begin
            m_cnt[i] = 0;
            if (int'(sel) < nch) m_ch[i] = int'(sel);
         end else begin
            m_cnt[i] = m_cnt[i] + 1;
            if (m_cnt[i] == dwell) begin
               m_cnt[i] = 0;
               m_ch[i]  = (m_ch[i] + 1) % nch;
            end
         end
         m_out[i]  = int'((data >> (m_ch[i] * 4)) & 16'h000F);
         m_sw[i]   = (m_ch[i] != prev) ? 1 : 0;
         m_scan[i] = mode ? 1 : 0;
      end
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: update model from the inputs present at the edge, then
   // compare all outputs of both instances 1 time unit later.
   task automatic step(input string tag);
      @(posedge clk);
      model_edge(0, 4, 4, in_a);
      model_edge(1, 3, 2, {4'h0, in_b});
      #1;
      chk({tag, ".a.out"}, int'(out_a), m_out[0]);
      chk({tag, ".a.ch"},  int'(ch_a),  m_ch[0]);
      chk({tag, ".a.sw"},  int'(sw_a),  m_sw[0]);
      chk({tag, ".b.out"}, int'(out_b), m_out[1]);
      chk({tag, ".b.ch"},  int'(ch_b),  m_ch[1]);
      chk({tag, ".b.sw"},  int'(sw_b),  m_sw[1]);
      $display("[TB] %s rst=%0b mode=%0b hold=%0b sel=%0d | a ch=%0d out=%h sw=%0b | b ch=%0d out=%h sw=%0b",
               tag, rst, mode, hold, sel, ch_a, out_a, sw_a, ch_b, out_b, sw_b);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      for (int i = 0; i < 2; i++) begin
         m_ch[i] = 0; m_cnt[i] = 0; m_scan[i] = 0; m_out[i] = 0; m_sw[i] = 0;
      end
      rst  = 1'b0;
      in_a = 16'hFFFF;
      in_b = 12'hFFF;
      sel  = 2'd0;
      mode = 1'b0;
      hold = 1'b0;

      // Reset for two cycles with all-ones input.
      step("reset0");
      step("reset1");
      chk("reset.out", int'(out_a), 0);
      chk("reset.ch",  int'(ch_a),  0);
      chk("reset.sw",  int'(sw_a),  0);
      rst = 1'b1;
      step("release");
      chk("release.out", int'(out_a), 15);

      // MANUAL sweep across all channels.
      in_a = 16'h4321;
      in_b = 12'h987;
      for (int k = 0; k < 4; k++) begin
         sel = 2'(k);
         step("sweep");
         chk("sweep.out", int'(out_a), k + 1);
         chk("sweep.ch",  int'(ch_a),  k);
      end

      // Out-of-range request on the 3-channel instance.
      sel = 2'd1;
      step("oor.set1");
      sel = 2'd3;
      step("oor.req3");
      chk("oor.ch",  int'(ch_b),  1);
      chk("oor.out", int'(out_b), 8);
      chk("oor.sw",  int'(sw_b),  0);

      // SCAN from channel 0.
      in_a = 16'hDCBA;
      sel  = 2'd0;
      step("scan.pre");
      mode = 1'b1;
      step("scan.enter");
      for (int i = 0; i < 16; i++) begin
         step("scan");
         chk("scan.ch",  int'(ch_a),  ((i + 1) / 4) % 4);
         chk("scan.out", int'(out_a), 10 + ((i + 1) / 4) % 4);
      end

      // Reach channel 1 with counter 2, then hold for 5 cycles.
      for (int i = 0; i < 6; i++) step("scan.to_hold");
      hold = 1'b1;
      in_a = 16'h5555;
      for (int i = 0; i < 5; i++) begin
         step("hold");
         chk("hold.ch",  int'(ch_a),  1);
         chk("hold.out", int'(out_a), 11);
         chk("hold.sw",  int'(sw_a),  0);
      end
      hold = 1'b0;
      in_a = 16'hDCBA;
      step("unhold1");
      chk("unhold1.ch", int'(ch_a), 1);
      step("unhold2");
      chk("unhold2.ch", int'(ch_a), 2);
      chk("unhold2.sw", int'(sw_a), 1);

      // Reset mid-scan with Mode kept at 1.
      rst = 1'b0;
      step("midreset");
      chk("midreset.ch",  int'(ch_a),  0);
      chk("midreset.out", int'(out_a), 0);
      rst = 1'b1;
      step("midreset.manual");
      for (int i = 0; i < 4; i++) begin
         step("rescan");
         chk("rescan.ch", int'(ch_a), (i == 3) ? 1 : 0);
      end

      // Randomized phase.
      for (int n = 0; n < 400; n++) begin
         in_a = 16'($urandom);
         in_b = 12'($urandom);
         sel  = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) mode = ~mode;
         hold = ($urandom_range(0, 4) == 0);
         rst  = ($urandom_range(0, 29) != 0);
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/param_mux_sequencer.md
Name: param_mux_sequencer

Overview:
Parametrised, registered N-channel, W-bit multiplexer with a built-in channel sequencer. In MANUAL mode it forwards the channel chosen by Select. In SCAN mode it steps through all channels automatically, dwelling a programmable number of cycles on each. It generalises the lab's 4-bit 2x1 mux to any width and channel count, adding registered output, hold, and auto-scan. It sits between multi-source data buses and a single downstream consumer (display driver, serialiser).

Parameters:
WIDTH, 4, bit width of each channel and of Out
NUM_CH, 4, number of input channels (2..16)
SEL_W, 2, width of Select/Ch_Out; must satisfy 2**SEL_W >= NUM_CH
DWELL, 4, cycles spent on each channel in SCAN mode (>= 1)

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-low reset (sampled on rising clk edge; rst=0 resets)
In  input  NUM_CH*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH]
Select  input  SEL_W  channel request, used in MANUAL mode only
Mode  input  1  0 = MANUAL, 1 = SCAN
Hold  input  1  1 = freeze all registers (outputs, counter, state)
Out  output  WIDTH  registered selected channel data
Ch_Out  output  SEL_W  index of channel currently driven on Out
Switched  output  1  one-cycle pulse when Ch_Out changes value

Behaviour:
- Reset (rst=0 at a clk edge): Out=0, Ch_Out=0, Switched=0, dwell counter=0, state=MANUAL. Reset has priority over Hold and Mode, including mid-scan.
- State register: MANUAL or SCAN. When Hold=0, the next state equals Mode each cycle, so a mode change takes effect one clock after it is sampled.
- Each non-held cycle: next_ch is computed per mode, then Ch_Out<=next_ch and Out<=In[next_ch]. Latency from In or Select to Out is 1 cycle. Out tracks In changes on the current channel every cycle, not only on a switch.
- MANUAL: next_ch = Select if Select < NUM_CH; otherwise next_ch = Ch_Out (an out-of-range request is ignored and the current channel is held). The dwell counter is forced to 0.
- SCAN: the counter increments each cycle. When counter == DWELL-1, the counter resets to 0 and next_ch = Ch_Out+1, wrapping from NUM_CH-1 to 0. Otherwise next_ch = Ch_Out. DWELL=1 advances every cycle. Wrap is at NUM_CH, not at 2**SEL_W.
- MANUAL->SCAN: the scan starts from the current Ch_Out with the counter at 0. The first advance therefore comes DWELL cycles after SCAN is entered.
- SCAN->MANUAL: the counter clears, and Select is honoured on the first MANUAL cycle.
- Hold=1: Out, Ch_Out, counter, and state all keep their values. Switched=0. Mode and Select are ignored. On release, operation resumes with the counter value that was frozen.
- Switched: registered. It is 1 in the cycle where the new Ch_Out first appears, when that value differs from the previous Ch_Out; otherwise 0. It is never asserted on the reset edge or while held.
- Purely synchronous. No combinational path from inputs to outputs.

Test Plan:
- Reset, with defaults (WIDTH=4, NUM_CH=4): drive rst=0 for 2 cycles with In=16'hFFFF -> Out=0, Ch_Out=0, Switched=0. Release rst -> Out=4'hF one cycle later.
- MANUAL sweep: In=16'h4321, Select stepped 0..3 once per cycle -> Out=1,2,3,4 and Ch_Out=0..3, each 1 cycle after Select. Switched=1 on each change.
- MANUAL out-of-range (NUM_CH=3, SEL_W=2): Select=3 while Ch_Out=1 -> Ch_Out stays 1, Out=In[1], Switched=0.
- SCAN with DWELL=4, In=16'hDCBA: Ch_Out sequence 0,0,0,0,1,1,1,1,2,...,3,0 -> Out A,B,C,D repeating. Switched pulses every 4th cycle, including on the 3->0 wrap.
- Hold during SCAN at counter=2 on channel 1: assert Hold for 5 cycles -> Out, Ch_Out frozen, Switched=0. After release, the advance to channel 2 occurs 2 cycles later.
- Reset mid-scan on channel 2 -> next cycle Ch_Out=0, Out=0, state MANUAL. With Mode held at 1, the scan restarts from channel 0 and first advances DWELL cycles later.
